traffic_light_monitor: RTL and testbench



---
 rtl/traffic_light_pkg.sv | 46 ++++
 rtl/seven_seg_decoder.sv | 22 ++
 rtl/traffic_light_monitor.sv | 127 ++++++++++++
 tb/tb_traffic_light_monitor.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/traffic_light_pkg.sv
// traffic_light_pkg: shared phase encodings, lamp patterns, segment patterns and default timings.
package traffic_light_pkg;

    typedef enum logic [2:0] {
        PH_SYNC   = 3'd0,
        PH_RED    = 3'd1,
        PH_RY     = 3'd2,
        PH_GREEN  = 3'd3,
        PH_GB     = 3'd4,
        PH_YELLOW = 3'd5
    } phase_e;

    // Lamp patterns as {green, yellow, red}
    localparam logic [2:0] L_OFF = 3'b000;
    localparam logic [2:0] L_RED = 3'b001;
    localparam logic [2:0] L_YEL = 3'b010;
    localparam logic [2:0] L_RY  = 3'b011;
    localparam logic [2:0] L_GRN = 3'b100;

    // Segment patterns, bit6=g .. bit0=a
    localparam logic [6:0] SEG_0 = 7'b0111111;
    localparam logic [6:0] SEG_1 = 7'b0000110;
    localparam logic [6:0] SEG_2 = 7'b1011011;
    localparam logic [6:0] SEG_3 = 7'b1001111;
    localparam logic [6:0] SEG_4 = 7'b1100110;
    localparam logic [6:0] SEG_5 = 7'b1101101;
    localparam logic [6:0] SEG_6 = 7'b1111101;
    localparam logic [6:0] SEG_7 = 7'b0000111;
    localparam logic [6:0] SEG_8 = 7'b1111111;
    localparam logic [6:0] SEG_9 = 7'b1101111;
    localparam logic [9:0][6:0] SEG_TABLE = {SEG_9, SEG_8, SEG_7, SEG_6, SEG_5,
                                             SEG_4, SEG_3, SEG_2, SEG_1, SEG_0};

    // Error type field of the first-error capture
    localparam logic [1:0] ET_SEQ = 2'd1;
    localparam logic [1:0] ET_TIM = 2'd2;
    localparam logic [1:0] ET_SEG = 2'd3;

    localparam int RED_CYC_DEF   = 10;
    localparam int RY_CYC_DEF    = 4;
    localparam int GREEN_CYC_DEF = 10;
    localparam int GB_CYC_DEF    = 6;
    localparam int Y_CYC_DEF     = 4;
    localparam int CNT_W_DEF     = 8;

endpackage

// File: rtl/seven_seg_decoder.sv
// seven_seg_decoder: maps a 7-segment pattern back to its BCD digit; unknown patterns give 0/invalid.
module seven_seg_decoder
    import traffic_light_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] digit,
    output logic       digit_valid
);

    // Search the ten legal patterns; patterns are unique so at most one matches
    always_comb begin
        digit       = 4'd0;
        digit_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (seg == SEG_TABLE[i]) begin
                digit       = 4'(i);
                digit_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor: passive phase/timing/display checker for a traffic-light controller.
// First-error capture on err_code is built only when TRAFFIC_LIGHT_MON_ERRCODE_EN is defined.
module traffic_light_monitor
    import traffic_light_pkg::*;
#(
    parameter int RED_CYC   = RED_CYC_DEF,
    parameter int RY_CYC    = RY_CYC_DEF,
    parameter int GREEN_CYC = GREEN_CYC_DEF,
    parameter int GB_CYC    = GB_CYC_DEF,
    parameter int Y_CYC     = Y_CYC_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       lamps,
    input  logic [6:0]       seg,
    input  logic             err_clr,
    output logic [2:0]       phase,
    output logic             in_sync,
    output logic [3:0]       digit,
    output logic             digit_valid,
    output logic             err_seq,
    output logic             err_timing,
    output logic             err_seg,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [3:0]       err_code
);

    logic [2:0] lamps_q;
    logic [6:0] seg_q;
    phase_e     ph, adv_ph, nxt;
    logic [2:0] adv_pat;
    logic [4:0] pcnt, exp_cyc, red_base;
    logic       adv, stay, seq_bad, tim_bad, seg_bad, dec_valid;
    logic [3:0] dec_digit, exp_digit;
    int         red_left;

    seven_seg_decoder u_dec (
        .seg         (seg_q),
        .digit       (dec_digit),
        .digit_valid (dec_valid)
    );

    // Per phase: patterns that hold the phase, the one pattern that advances it, and its length.
    // SYNC tolerates every legal pattern so a restarted monitor waits quietly for the next red.
    always_comb begin
        adv_pat = L_RED;
        adv_ph  = PH_RED;
        exp_cyc = 5'd0;
        stay    = 1'b0;
        case (ph)
            PH_SYNC:   stay = lamps_q inside {L_OFF, L_YEL, L_RY, L_GRN};
            PH_RED:    begin adv_pat = L_RY;  adv_ph = PH_RY;     exp_cyc = 5'(RED_CYC);   stay = lamps_q == L_RED; end
            PH_RY:     begin adv_pat = L_GRN; adv_ph = PH_GREEN;  exp_cyc = 5'(RY_CYC);    stay = lamps_q == L_RY; end
            PH_GREEN:  begin adv_pat = L_OFF; adv_ph = PH_GB;     exp_cyc = 5'(GREEN_CYC); stay = lamps_q == L_GRN; end
            PH_GB:     begin adv_pat = L_YEL; adv_ph = PH_YELLOW; exp_cyc = 5'(GB_CYC);    stay = lamps_q inside {L_OFF, L_GRN}; end
            PH_YELLOW: begin exp_cyc = 5'(Y_CYC); stay = lamps_q == L_YEL; end
            default:   ;
        endcase
    end

    assign adv       = lamps_q == adv_pat;
    assign nxt       = adv ? adv_ph : stay ? ph : PH_SYNC;
    assign seq_bad   = !adv && !stay;
    assign tim_bad   = adv && ph != PH_SYNC && pcnt != exp_cyc;
    // Red countdown: entry sample shows RED_CYC-1, clamped at 0 if red overstays
    assign red_base  = adv ? 5'd0 : pcnt;
    assign red_left  = RED_CYC - 1 - int'(red_base);
    assign exp_digit = (nxt == PH_RED && red_left > 0) ? 4'(red_left) : 4'd0;
    assign seg_bad   = nxt != PH_SYNC && !(dec_valid && dec_digit == exp_digit);
    assign phase     = ph;

    // Stage 1: register the controller pins
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lamps_q <= 3'd0;
            seg_q   <= 7'd0;
        end else begin
            lamps_q <= lamps;
            seg_q   <= seg;
        end
    end

    // Stage 2: phase tracking, counters, decoded display and sticky error flags
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ph          <= PH_SYNC;
            in_sync     <= 1'b0;
            pcnt        <= 5'd0;
            digit       <= 4'd0;
            digit_valid <= 1'b0;
            err_seq     <= 1'b0;
            err_timing  <= 1'b0;
            err_seg     <= 1'b0;
            cycle_cnt   <= '0;
        end else begin
            ph          <= nxt;
            in_sync     <= nxt != PH_SYNC;
            pcnt        <= adv ? 5'd1 : (pcnt == 5'h1f ? pcnt : pcnt + 5'd1);
            digit       <= dec_digit;
            digit_valid <= dec_valid;
            err_seq     <= seq_bad || (err_seq && !err_clr);
            err_timing  <= tim_bad || (err_timing && !err_clr);
            err_seg     <= seg_bad || (err_seg && !err_clr);
            if (adv && ph == PH_YELLOW && cycle_cnt != {CNT_W{1'b1}})
                cycle_cnt <= cycle_cnt + CNT_W'(1);
        end
    end

`ifdef TRAFFIC_LIGHT_MON_ERRCODE_EN
    logic [1:0] err_type;
    assign err_type = seq_bad ? ET_SEQ : tim_bad ? ET_TIM : ET_SEG;

    // Hold the first error's type and phase; err_clr re-arms, and an error in the same cycle is kept
    always_ff @(posedge clk) begin
        if (!rst_n)
            err_code <= 4'd0;
        else if ((seq_bad || tim_bad || seg_bad) && (err_clr || err_code == 4'd0))
            err_code <= {err_type, phase[1:0]};
        else if (err_clr)
            err_code <= 4'd0;
    end
`else
    assign err_code = 4'd0;
`endif

endmodule

// File: tb/tb_traffic_light_monitor.sv
// tb_traffic_light_monitor: directed stimulus with a phase-table reference model and literal checkpoints.
module tb_traffic_light_monitor;

    localparam int RED_CYC = 10;

    logic       clk, rst_n, err_clr, in_sync, digit_valid, err_seq, err_timing, err_seg;
    logic [2:0] lamps, phase;
    logic [6:0] seg;
    logic [3:0] digit, err_code;
    logic [7:0] cycle_cnt;

    traffic_light_monitor dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .lamps       (lamps),
        .seg         (seg),
        .err_clr     (err_clr),
        .phase       (phase),
        .in_sync     (in_sync),
        .digit       (digit),
        .digit_valid (digit_valid),
        .err_seq     (err_seq),
        .err_timing  (err_timing),
        .err_seg     (err_seg),
        .cycle_cnt   (cycle_cnt),
        .err_code    (err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Phase table indexed by phase number (0 SYNC .. 5 YELLOW)
    int         ADV_L  [6] = '{1, 3, 4, 0, 2, 1};
    int         ADV_TO [6] = '{1, 2, 3, 4, 5, 1};
    int         CYC    [6] = '{0, 10, 4, 10, 6, 4};
    logic [7:0] STAY   [6] = '{8'h1D, 8'h02, 8'h08, 8'h10, 8'h11, 8'h04};
    logic [6:0] PAT    [10] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
                                7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111};

    int         n_cmp = 0, n_bad = 0;
    bit         chk_en = 0;
    int         m_ph, m_run, m_cyc, m_dig, m_code, np, nrun, want, d, ty;
    bit         m_eseq, m_etim, m_eseg, m_val, adv_m, stay_m, eq, et, es;
    logic [2:0] s1_l;
    logic [6:0] s1_s;

    function automatic int dec(input logic [6:0] s);
        for (int i = 0; i < 10; i++) if (s == PAT[i]) return i;
        return -1;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: consumes the sample captured one edge earlier
    always @(posedge clk) begin
        if (!rst_n) begin
            m_ph = 0; m_run = 0; m_cyc = 0; m_dig = 0; m_val = 0; m_code = 0;
            m_eseq = 0; m_etim = 0; m_eseg = 0; s1_l = 0; s1_s = 0;
        end else begin
            adv_m  = int'(s1_l) == ADV_L[m_ph];
            stay_m = STAY[m_ph][s1_l];
            np     = adv_m ? ADV_TO[m_ph] : stay_m ? m_ph : 0;
            nrun   = adv_m ? 1 : m_run + 1;
            d      = dec(s1_s);
            want   = (np == 1 && RED_CYC - nrun > 0) ? RED_CYC - nrun : 0;
            eq     = !adv_m && !stay_m;
            et     = adv_m && m_ph != 0 && m_run != CYC[m_ph];
            es     = np != 0 && d != want;
`ifdef TRAFFIC_LIGHT_MON_ERRCODE_EN
            ty = eq ? 1 : et ? 2 : 3;
            if ((eq || et || es) && (err_clr || m_code == 0)) m_code = ty * 4 + m_ph % 4;
            else if (err_clr) m_code = 0;
`endif
            if (adv_m && m_ph == 5 && m_cyc < 255) m_cyc++;
            m_eseq = eq || (m_eseq && !err_clr);
            m_etim = et || (m_etim && !err_clr);
            m_eseg = es || (m_eseg && !err_clr);
            m_dig  = d < 0 ? 0 : d;
            m_val  = d >= 0;
            m_ph   = np;
            m_run  = nrun;
            s1_l   = lamps;
            s1_s   = seg;
        end
    end

    // Compare every cycle once reset has been applied
    always @(negedge clk) begin
        if (chk_en) begin
            check("phase", phase, m_ph);
            check("in_sync", in_sync, m_ph != 0);
            check("digit", digit, m_dig);
            check("digit_valid", digit_valid, m_val);
            check("err_seq", err_seq, m_eseq);
            check("err_timing", err_timing, m_etim);
            check("err_seg", err_seg, m_eseg);
            check("cycle_cnt", cycle_cnt, m_cyc);
            check("err_code", err_code, m_code);
        end
    end

    // Inputs change on the falling edge; after return, outputs reflect the previous drive's vector
    task automatic drive(input logic [2:0] l, input logic [6:0] s, input logic c);
        lamps = l; seg = s; err_clr = c;
        @(negedge clk);
    endtask

    // One sample of the nominal controller cycle: R10 (9..0), RY4, G10, GB6 (000 first), Y4
    task automatic gold(input int i, input logic c);
        if (i < 10)      drive(3'b001, PAT[9 - i], c);
        else if (i < 14) drive(3'b011, PAT[0], c);
        else if (i < 24) drive(3'b100, PAT[0], c);
        else if (i < 30) drive(((i - 24) % 2 == 0) ? 3'b000 : 3'b100, PAT[0], c);
        else             drive(3'b010, PAT[0], c);
    endtask

    initial begin
        rst_n = 0; lamps = 0; seg = 0; err_clr = 0;
        @(negedge clk);
        chk_en = 1;
        check("rst_phase", phase, 0);
        check("rst_cycle_cnt", cycle_cnt, 0);
        check("rst_err_code", err_code, 0);
        rst_n = 1;
        for (int i = 0; i < 6; i++) drive((i % 2) ? 3'b010 : 3'b000, 7'd0, 0);
        gold(0, 0);
        check("t1_pre_in_sync", in_sync, 0);
        gold(1, 0);
        check("t1_in_sync", in_sync, 1);
        check("t1_digit", digit, 9);
        for (int i = 2; i < 34; i++) gold(i, 0);
        gold(0, 0); gold(1, 0);
        check("t1_cycle_cnt", cycle_cnt, 1);
        check("t1_phase", phase, 1);
        check("t1_errs", {err_seq, err_timing, err_seg}, 0);
        for (int i = 2; i < 10; i++) gold(i, 0);
        drive(3'b001, PAT[0], 0);
        gold(10, 0); gold(11, 0);
        check("t2_err_timing", err_timing, 1);
        check("t2_phase", phase, 2);
`ifdef TRAFFIC_LIGHT_MON_ERRCODE_EN
        check("t2_err_code", err_code, 9);
`endif
        for (int i = 12; i < 34; i++) gold(i, 0);
        gold(0, 1);
        for (int i = 1; i < 16; i++) gold(i, 0);
        drive(3'b101, PAT[0], 0);
        drive(3'b100, PAT[0], 0);
        check("t3_err_seq", err_seq, 1);
        check("t3_phase", phase, 0);
        check("t3_in_sync", in_sync, 0);
        gold(0, 0); gold(1, 0);
        check("t3_resync", phase, 1);
        drive(3'b001, PAT[5], 0);
        gold(3, 0);
        check("t4_err_seg", err_seg, 1);
        check("t4_digit", digit, 5);
        gold(4, 1);
        drive(3'b001, 7'b0000001, 0);
        gold(6, 0);
        check("t4_bad_valid", digit_valid, 0);
        check("t4_bad_digit", digit, 0);
        check("t4_bad_err_seg", err_seg, 1);
        gold(7, 1);
        for (int i = 8; i < 34; i++) gold(i, 0);
        for (int i = 0; i < 9; i++) gold(i, 0);
        gold(10, 0);
        gold(11, 1);
        check("t5_clr_vs_timing", err_timing, 1);
`ifdef TRAFFIC_LIGHT_MON_ERRCODE_EN
        check("t5_err_code", err_code, 9);
`endif
        gold(12, 1);
        check("t5_cleared", {err_seq, err_timing, err_seg}, 0);
        check("t5_code_cleared", err_code, 0);
        for (int i = 13; i < 34; i++) gold(i, 0);
        for (int c = 0; c < 260; c++) for (int i = 0; i < 34; i++) gold(i, 0);
        gold(0, 0); gold(1, 0);
        check("t6_saturate", cycle_cnt, 255);
        for (int i = 2; i < 21; i++) gold(i, 0);
        rst_n = 0;
        gold(21, 0);
        rst_n = 1;
        check("t6_rst_phase", phase, 0);
        check("t6_rst_in_sync", in_sync, 0);
        check("t6_rst_digit", {digit_valid, digit}, 0);
        check("t6_rst_errs", {err_seq, err_timing, err_seg}, 0);
        check("t6_rst_cycle_cnt", cycle_cnt, 0);
        check("t6_rst_err_code", err_code, 0);
        for (int i = 22; i < 34; i++) gold(i, 0);
        for (int i = 0; i < 34; i++) gold(i, 0);
        gold(0, 0); gold(1, 0);
        check("t6_resync_phase", phase, 1);
        check("t6_resync_errs", {err_seq, err_timing, err_seg}, 0);
        check("t6_resync_cycles", cycle_cnt, 1);
        chk_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
